// File: rtl/pipeline_mem_to_wb_skid_register.sv
// MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// The head (main) entry drives every output; the skid entry only catches one extra accept.
module pipeline_mem_to_wb_skid_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int COUNT_WIDTH    = 16,
  parameter bit ZERO_REG_GUARD = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_WIDTH-1:0]  rd_write_address_in,
  input  logic                   rd_select_in,
  input  logic                   rd_write_enable_in,
  input  logic [DATA_WIDTH-1:0]  alu_result_in,
  input  logic [DATA_WIDTH-1:0]  dmem_data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_WIDTH-1:0]  rd_write_address_out,
  output logic                   rd_select_out,
  output logic                   rd_write_enable_out,
  output logic [DATA_WIDTH-1:0]  alu_result_out,
  output logic [DATA_WIDTH-1:0]  dmem_data_out,
  output logic [DATA_WIDTH-1:0]  wb_data_out,
  output logic [1:0]             occupancy,
  output logic [COUNT_WIDTH-1:0] retire_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;

  logic [ADDR_WIDTH-1:0]  r_main_addr;
  logic                   r_main_sel;
  logic                   r_main_en;
  logic [DATA_WIDTH-1:0]  r_main_alu;
  logic [DATA_WIDTH-1:0]  r_main_dmem;

  logic [ADDR_WIDTH-1:0]  r_skid_addr;
  logic                   r_skid_sel;
  logic                   r_skid_en;
  logic [DATA_WIDTH-1:0]  r_skid_alu;
  logic [DATA_WIDTH-1:0]  r_skid_dmem;

  logic [COUNT_WIDTH-1:0] r_retire_count;

  logic                   w_in_ready;
  logic                   w_out_valid;
  logic [1:0]             w_occupancy;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_load_main_from_in;
  logic                   w_load_main_from_skid;
  logic                   w_load_skid;
  logic                   w_addr_is_zero;

  // Handshake flags decode registered state only, so out_ready never reaches in_ready.
  always_comb begin
    w_in_ready  = 1'b1;
    w_out_valid = 1'b0;
    w_occupancy = 2'd0;
    case (r_state)
      S_EMPTY: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_occupancy = 2'd0;
      end
      S_ONE: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
        w_occupancy = 2'd1;
      end
      S_FULL: begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b1;
        w_occupancy = 2'd2;
      end
      default: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        w_occupancy = 2'd0;
      end
    endcase
  end

  assign w_accept = in_valid & w_in_ready;
  assign w_pop    = w_out_valid & out_ready;

  // Next-state and payload-load decisions; flush overrides every transition.
  always_comb begin
    w_state_next          = r_state;
    w_load_main_from_in   = 1'b0;
    w_load_main_from_skid = 1'b0;
    w_load_skid           = 1'b0;
    if (flush) begin
      w_state_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_next        = S_ONE;
            w_load_main_from_in = 1'b1;
          end else begin
            w_state_next = S_EMPTY;
          end
        end
        S_ONE: begin
          if (w_accept && w_pop) begin
            w_state_next        = S_ONE;
            w_load_main_from_in = 1'b1;
          end else if (w_accept) begin
            w_state_next = S_FULL;
            w_load_skid  = 1'b1;
          end else if (w_pop) begin
            w_state_next = S_EMPTY;
          end else begin
            w_state_next = S_ONE;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            w_state_next          = S_ONE;
            w_load_main_from_skid = 1'b1;
          end else begin
            w_state_next = S_FULL;
          end
        end
        default: begin
          w_state_next = S_EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Head entry: refilled from the input or promoted from the skid slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_main_addr <= {ADDR_WIDTH{1'b0}};
      r_main_sel  <= 1'b0;
      r_main_en   <= 1'b0;
      r_main_alu  <= {DATA_WIDTH{1'b0}};
      r_main_dmem <= {DATA_WIDTH{1'b0}};
    end else if (w_load_main_from_in) begin
      r_main_addr <= rd_write_address_in;
      r_main_sel  <= rd_select_in;
      r_main_en   <= rd_write_enable_in;
      r_main_alu  <= alu_result_in;
      r_main_dmem <= dmem_data_in;
    end else if (w_load_main_from_skid) begin
      r_main_addr <= r_skid_addr;
      r_main_sel  <= r_skid_sel;
      r_main_en   <= r_skid_en;
      r_main_alu  <= r_skid_alu;
      r_main_dmem <= r_skid_dmem;
    end else begin
      r_main_addr <= r_main_addr;
      r_main_sel  <= r_main_sel;
      r_main_en   <= r_main_en;
      r_main_alu  <= r_main_alu;
      r_main_dmem <= r_main_dmem;
    end
  end

  // Skid entry: captures the second arrival while the head is stalled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_skid_addr <= {ADDR_WIDTH{1'b0}};
      r_skid_sel  <= 1'b0;
      r_skid_en   <= 1'b0;
      r_skid_alu  <= {DATA_WIDTH{1'b0}};
      r_skid_dmem <= {DATA_WIDTH{1'b0}};
    end else if (w_load_skid) begin
      r_skid_addr <= rd_write_address_in;
      r_skid_sel  <= rd_select_in;
      r_skid_en   <= rd_write_enable_in;
      r_skid_alu  <= alu_result_in;
      r_skid_dmem <= dmem_data_in;
    end else begin
      r_skid_addr <= r_skid_addr;
      r_skid_sel  <= r_skid_sel;
      r_skid_en   <= r_skid_en;
      r_skid_alu  <= r_skid_alu;
      r_skid_dmem <= r_skid_dmem;
    end
  end

  // Retire counter: a pop still counts during flush because the consumer already took it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_retire_count <= {COUNT_WIDTH{1'b0}};
    end else if (w_pop) begin
      r_retire_count <= r_retire_count + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      r_retire_count <= r_retire_count;
    end
  end

  assign w_addr_is_zero = (r_main_addr == {ADDR_WIDTH{1'b0}});

  assign in_ready             = w_in_ready;
  assign out_valid            = w_out_valid;
  assign occupancy            = w_occupancy;
  assign retire_count         = r_retire_count;
  assign rd_write_address_out = r_main_addr;
  assign rd_select_out        = r_main_sel;
  assign alu_result_out       = r_main_alu;
  assign dmem_data_out        = r_main_dmem;
  assign wb_data_out          = r_main_sel ? r_main_dmem : r_main_alu;
  assign rd_write_enable_out  = w_out_valid & r_main_en & ~(ZERO_REG_GUARD & w_addr_is_zero);

endmodule

// File: tb/tb_pipeline_mem_to_wb_skid_register.sv
// Bench for the MEM->WB skid register: directed scenarios then random traffic,
// checked against a queue-based model of a 2-deep in-order buffer.
module tb_pipeline_mem_to_wb_skid_register;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [4:0]  addr_in;
  logic        sel_in;
  logic        en_in;
  logic [31:0] alu_in;
  logic [31:0] dmem_in;

  logic        in_ready, out_valid, sel_out, wren_out;
  logic [4:0]  addr_out;
  logic [31:0] alu_out, dmem_out, wb_out;
  logic [1:0]  occ;
  logic [15:0] rcount;

  logic        ng_in_ready, ng_out_valid, ng_sel_out, ng_wren_out;
  logic [4:0]  ng_addr_out;
  logic [31:0] ng_alu_out, ng_dmem_out, ng_wb_out;
  logic [1:0]  ng_occ;
  logic [15:0] ng_rcount;

  logic        c2_in_ready, c2_out_valid, c2_sel_out, c2_wren_out;
  logic [4:0]  c2_addr_out;
  logic [31:0] c2_alu_out, c2_dmem_out, c2_wb_out;
  logic [1:0]  c2_occ;
  logic [1:0]  c2_rcount;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic        s;
    logic        e;
    logic [31:0] alu;
    logic [31:0] dm;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_count;

  pipeline_mem_to_wb_skid_register dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd_write_address_in(addr_in), .rd_select_in(sel_in), .rd_write_enable_in(en_in),
    .alu_result_in(alu_in), .dmem_data_in(dmem_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_write_address_out(addr_out), .rd_select_out(sel_out), .rd_write_enable_out(wren_out),
    .alu_result_out(alu_out), .dmem_data_out(dmem_out), .wb_data_out(wb_out),
    .occupancy(occ), .retire_count(rcount)
  );

  pipeline_mem_to_wb_skid_register #(.ZERO_REG_GUARD(1'b0)) dut_ng (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(ng_in_ready),
    .rd_write_address_in(addr_in), .rd_select_in(sel_in), .rd_write_enable_in(en_in),
    .alu_result_in(alu_in), .dmem_data_in(dmem_in),
    .out_valid(ng_out_valid), .out_ready(out_ready),
    .rd_write_address_out(ng_addr_out), .rd_select_out(ng_sel_out), .rd_write_enable_out(ng_wren_out),
    .alu_result_out(ng_alu_out), .dmem_data_out(ng_dmem_out), .wb_data_out(ng_wb_out),
    .occupancy(ng_occ), .retire_count(ng_rcount)
  );

  pipeline_mem_to_wb_skid_register #(.COUNT_WIDTH(2)) dut_c2 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(c2_in_ready),
    .rd_write_address_in(addr_in), .rd_select_in(sel_in), .rd_write_enable_in(en_in),
    .alu_result_in(alu_in), .dmem_data_in(dmem_in),
    .out_valid(c2_out_valid), .out_ready(out_ready),
    .rd_write_address_out(c2_addr_out), .rd_select_out(c2_sel_out), .rd_write_enable_out(c2_wren_out),
    .alu_result_out(c2_alu_out), .dmem_data_out(c2_dmem_out), .wb_data_out(c2_wb_out),
    .occupancy(c2_occ), .retire_count(c2_rcount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every DUT against the model's current contents.
  task automatic check_all();
    ent_t h;
    logic v;
    v = (q.size() > 0);
    chk("out_valid", {63'd0, out_valid}, {63'd0, v});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < 2)});
    chk("occupancy", {62'd0, occ}, 64'(q.size()));
    chk("retire_count", {48'd0, rcount}, {48'd0, m_count});
    chk("c2_retire_count", {62'd0, c2_rcount}, {62'd0, m_count[1:0]});
    chk("ng_out_valid", {63'd0, ng_out_valid}, {63'd0, v});
    if (v) begin
      h = q[0];
      chk("addr_out", {59'd0, addr_out}, {59'd0, h.a});
      chk("sel_out", {63'd0, sel_out}, {63'd0, h.s});
      chk("alu_out", {32'd0, alu_out}, {32'd0, h.alu});
      chk("dmem_out", {32'd0, dmem_out}, {32'd0, h.dm});
      chk("wb_data_out", {32'd0, wb_out}, {32'd0, (h.s ? h.dm : h.alu)});
      chk("wren_guard", {63'd0, wren_out}, {63'd0, (h.e && (h.a != 5'd0))});
      chk("wren_noguard", {63'd0, ng_wren_out}, {63'd0, h.e});
    end else begin
      chk("wren_idle", {63'd0, wren_out}, 64'd0);
      chk("ng_wren_idle", {63'd0, ng_wren_out}, 64'd0);
    end
  endtask

  // Check, apply one clock of stimulus, advance the model, land on the next falling edge.
  task automatic cycle(input logic iv, input logic [4:0] a, input logic s, input logic e,
                       input logic [31:0] alu, input logic [31:0] dm,
                       input logic ordy, input logic fl);
    ent_t ne;
    logic pop, acc;
    in_valid = iv; addr_in = a; sel_in = s; en_in = e;
    alu_in = alu; dmem_in = dm; out_ready = ordy; flush = fl;
    check_all();
    pop = (q.size() > 0) && ordy;
    acc = iv && (q.size() < 2);
    ne = '{a: a, s: s, e: e, alu: alu, dm: dm};
    if (pop) m_count = m_count + 16'd1;
    if (fl) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(ne);
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_addr"}, {59'd0, addr_out}, 64'd0);
    chk({tag, "_sel"}, {63'd0, sel_out}, 64'd0);
    chk({tag, "_wren"}, {63'd0, wren_out}, 64'd0);
    chk({tag, "_alu"}, {32'd0, alu_out}, 64'd0);
    chk({tag, "_dmem"}, {32'd0, dmem_out}, 64'd0);
    chk({tag, "_wb"}, {32'd0, wb_out}, 64'd0);
    chk({tag, "_occ"}, {62'd0, occ}, 64'd0);
    chk({tag, "_count"}, {48'd0, rcount}, 64'd0);
    chk({tag, "_c2_count"}, {62'd0, c2_rcount}, 64'd0);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    addr_in = 5'd0; sel_in = 1'b0; en_in = 1'b0; alu_in = 32'd0; dmem_in = 32'd0;
    m_count = 16'd0;
    @(negedge clock); @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clock);

    // Streaming at full rate.
    for (int i = 1; i <= 4; i++)
      cycle(1'b1, 5'(i), 1'b0, 1'b1, 32'(i * 16), 32'hD000_0000 + 32'(i), 1'b1, 1'b0);
    chk("stream_occ", {62'd0, occ}, 64'd1);
    cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("stream_count", {48'd0, rcount}, 64'd4);
    chk("stream_c2_wrap", {62'd0, c2_rcount}, 64'd0);

    // Backpressure fills the skid slot, then drains in order.
    cycle(1'b1, 5'd5, 1'b0, 1'b1, 32'h0000_00AA, 32'h0000_0011, 1'b0, 1'b0);
    cycle(1'b1, 5'd6, 1'b1, 1'b1, 32'h0000_0022, 32'h0000_00BB, 1'b0, 1'b0);
    chk("bp_occ_full", {62'd0, occ}, 64'd2);
    chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("bp_head_a", {59'd0, addr_out}, 64'd5);
    cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    chk("bp_wb_b", {32'd0, wb_out}, 64'h0000_00BB);
    cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Simultaneous accept and pop in ONE.
    cycle(1'b1, 5'd7, 1'b0, 1'b1, 32'h0000_0077, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 5'd8, 1'b0, 1'b1, 32'h0000_0088, 32'd0, 1'b1, 1'b0);
    chk("ap_occ", {62'd0, occ}, 64'd1);
    chk("ap_head", {59'd0, addr_out}, 64'd8);

    // Flush while FULL with a new entry offered.
    cycle(1'b1, 5'd9, 1'b0, 1'b1, 32'h0000_0099, 32'd0, 1'b0, 1'b0);
    cycle(1'b1, 5'd10, 1'b0, 1'b1, 32'h0000_00A0, 32'd0, 1'b0, 1'b1);
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    chk("flush_occ", {62'd0, occ}, 64'd0);
    chk("flush_wren", {63'd0, wren_out}, 64'd0);
    cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);

    // Writes to x0 with and without the guard.
    cycle(1'b1, 5'd0, 1'b0, 1'b1, 32'h0000_0123, 32'd0, 1'b0, 1'b0);
    chk("x0_valid", {63'd0, out_valid}, 64'd1);
    chk("x0_guard_on", {63'd0, wren_out}, 64'd0);
    chk("x0_guard_off", {63'd0, ng_wren_out}, 64'd1);

    // Fill, then hit asynchronous reset between clock edges.
    cycle(1'b1, 5'd3, 1'b1, 1'b1, 32'h0000_0456, 32'h0000_0789, 1'b0, 1'b0);
    check_all();
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clock);
    reset = 1'b0;
    q.delete(); m_count = 16'd0;

    // Two-bit counter wrap: three pops then one more.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 5'(i + 1), 1'b0, 1'b1, 32'(i), 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("c2_count_3", {62'd0, c2_rcount}, 64'd3);
    cycle(1'b1, 5'd4, 1'b0, 1'b1, 32'd4, 32'd0, 1'b1, 1'b0);
    cycle(1'b0, 5'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("c2_count_wrap", {62'd0, c2_rcount}, 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), 1'($urandom),
            1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 19) == 0));
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_mem_to_wb_skid_register.md
Name: pipeline_mem_to_wb_skid_register

Overview:
- Parametrised MEM->WB pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Sits between the data-memory stage and register-file writeback.
- Absorbs writeback-side backpressure without a combinational ready path.
- Provides flush, x0 write suppression, a pre-muxed writeback value and a retire counter.

Parameters:
- DATA_WIDTH, 32, width of alu_result, dmem_data and wb_data.
- ADDR_WIDTH, 5, register-file address width.
- COUNT_WIDTH, 16, width of the retire counter.
- ZERO_REG_GUARD, 1, when 1, writes to address 0 never assert rd_write_enable_out.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous pipeline flush
- in_valid  in  1  MEM stage presents an entry
- in_ready  out  1  block can accept an entry this cycle
- rd_write_address_in  in  ADDR_WIDTH  destination register
- rd_select_in  in  1  writeback source: 1 = dmem data, 0 = ALU result
- rd_write_enable_in  in  1  entry writes the register file
- alu_result_in  in  DATA_WIDTH  ALU result
- dmem_data_in  in  DATA_WIDTH  load data
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback consumes the head entry
- rd_write_address_out  out  ADDR_WIDTH  head destination
- rd_select_out  out  1  head source select
- rd_write_enable_out  out  1  gated write enable
- alu_result_out  out  DATA_WIDTH  head ALU result
- dmem_data_out  out  DATA_WIDTH  head load data
- wb_data_out  out  DATA_WIDTH  rd_select_out ? dmem_data_out : alu_result_out
- occupancy  out  2  entries held, 0..2
- retire_count  out  COUNT_WIDTH  popped entries, wraps

Behaviour:
- Storage and events:
  - Two entries: main (head, drives all *_out) and skid. Each entry holds address, select, enable, alu and dmem fields.
  - accept = in_valid & in_ready; pop = out_valid & out_ready.
- States:
  - EMPTY: occupancy 0, out_valid 0, in_ready 1.
  - ONE: occupancy 1, out_valid 1, in_ready 1.
  - FULL: occupancy 2, out_valid 1, in_ready 0.
  - in_ready is a decode of registered state only; no combinational path from out_ready to in_ready.
- Transitions, applied on the clock edge when flush is 0:
  - EMPTY, accept: -> ONE; main <= in.
  - ONE, accept & pop: stay ONE; main <= in.
  - ONE, accept & !pop: -> FULL; skid <= in; main unchanged.
  - ONE, !accept & pop: -> EMPTY.
  - FULL, pop: -> ONE; main <= skid. Accept is impossible because in_ready = 0.
  - No event: hold state and all contents.
- Ordering: entries leave in arrival order; nothing is dropped or duplicated.
- Latency: an entry accepted into EMPTY appears on the outputs 1 cycle later. Throughput is 1 entry/cycle while out_ready = 1.
- Flush:
  - flush = 1 at an edge forces EMPTY and clears both valid bits.
  - An accept in the same cycle is discarded.
  - Payload registers may hold stale data, but rd_write_enable_out is forced 0 because out_valid = 0.
- rd_write_enable_out = out_valid & main.enable & !(ZERO_REG_GUARD & (rd_write_address_out == 0)).
- wb_data_out is combinational from main registers only.
- retire_count:
  - Increments by 1 on every pop, including a pop in a flush cycle, since the consumer has already sampled the entry.
  - Wraps from 2^COUNT_WIDTH-1 to 0.
  - Flush does not clear it.
- Reset, asynchronous and valid mid-operation:
  - Forces EMPTY.
  - All outputs 0: out_valid, rd_write_address_out, rd_select_out, rd_write_enable_out, alu_result_out, dmem_data_out, wb_data_out, occupancy, retire_count.
  - in_ready = 1 after reset.
  - Skid contents cleared to 0.
- X-safety: no output depends on skid contents while in EMPTY or ONE.

Test Plan:
- Streaming: out_ready = 1, in_valid = 1 for 4 cycles with addresses 1,2,3,4 and alu 0x10..0x40. Required: each entry appears 1 cycle after its accept, in order; occupancy stays at 1; retire_count = 4.
- Backpressure: out_ready = 0, push A (addr 5, alu 0xAA) then B (addr 6, dmem 0xBB, sel 1). Required: occupancy 2, in_ready 0, head = A. Then raise out_ready: A, then B with wb_data_out = 0xBB; in_ready returns to 1 the cycle after the first pop.
- Simultaneous accept and pop in ONE: head stays valid and is replaced by the new entry next cycle; occupancy remains 1; retire_count +1.
- Flush in FULL with in_valid = 1: next cycle out_valid = 0, occupancy = 0, in_ready = 1, rd_write_enable_out = 0; the incoming entry is never output.
- x0 guard: entry with addr 0, enable 1, ZERO_REG_GUARD = 1 -> out_valid 1, rd_write_enable_out 0. Same entry with ZERO_REG_GUARD = 0 -> rd_write_enable_out 1.
- Async reset asserted mid-cycle while FULL: all outputs 0 immediately without waiting for a clock edge. retire_count preset near wrap (COUNT_WIDTH = 2, 3 pops then 1 more) -> count reads 3 then 0.
